// File: rtl/uart_rx_img_loader.sv
// uart_rx_img_loader: collects a fixed-length byte stream from the UART receiver
// and writes it into the image RAM from address 0 upward. It reports completion
// with load_done, or an inter-byte timeout abort with load_err.
module uart_rx_img_loader #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned IMG_BYTES      = 65536,
    parameter int unsigned TO_W           = 24,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    // Count value at which the incoming byte is the final one of the image.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);

    // Idle-count value on which a missing byte aborts the load.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_next;

    logic              mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [7:0]        mem_wdata_next;
    logic              busy_next;
    logic              load_done_next;
    logic              load_err_next;
    logic [CNT_W-1:0]  byte_count_next;

    logic              last_byte_c;

    assign last_byte_c = (byte_count == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-counter and next-output logic.
    always_comb begin
        state_next      = state;
        wr_addr_next    = wr_addr;
        to_cnt_next     = to_cnt;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        load_done_next  = 1'b0;
        load_err_next   = 1'b0;
        byte_count_next = byte_count;

        case (state)
            ST_IDLE: begin
                // A tick arriving with start belongs to no load and is dropped.
                if (start) begin
                    state_next      = ST_ARMED;
                    wr_addr_next    = '0;
                    to_cnt_next     = '0;
                    byte_count_next = '0;
                end
            end

            ST_ARMED, ST_LOAD: begin
                if (rx_done_tick) begin
                    // A byte always beats a same-cycle timeout expiry.
                    mem_we_next     = 1'b1;
                    mem_addr_next   = wr_addr;
                    mem_wdata_next  = rx_data;
                    wr_addr_next    = wr_addr + ADDR_W'(1);
                    byte_count_next = byte_count + CNT_W'(1);
                    to_cnt_next     = '0;
                    if (last_byte_c) begin
                        load_done_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        state_next     = ST_LOAD;
                    end
                end else if (state == ST_LOAD) begin
                    // Only LOAD is timed; ARMED waits indefinitely for the first byte.
                    if (to_cnt == TO_LAST) begin
                        load_err_next = 1'b1;
                        to_cnt_next   = '0;
                        state_next    = ST_IDLE;
                    end else begin
                        to_cnt_next   = to_cnt + TO_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_ARMED) || (state_next == ST_LOAD);
    end

    // Registered outputs and internal counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr    <= '0;
            to_cnt     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= '0;
        end else begin
            wr_addr    <= wr_addr_next;
            to_cnt     <= to_cnt_next;
            mem_we     <= mem_we_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            busy       <= busy_next;
            load_done  <= load_done_next;
            load_err   <= load_err_next;
            byte_count <= byte_count_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_img_loader.sv
// Directed bench for uart_rx_img_loader with a 4-byte image and a 20-cycle timeout.
module tb_uart_rx_img_loader;

    localparam int unsigned ADDR_W         = 4;
    localparam int unsigned IMG_BYTES      = 4;
    localparam int unsigned TO_W           = 8;
    localparam int unsigned TIMEOUT_CYCLES = 20;
    localparam int unsigned CW             = ADDR_W + 1;

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic              start        = 1'b0;
    logic              rx_done_tick = 1'b0;
    logic [7:0]        rx_data      = 8'h00;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   byte_count;

    int checks     = 0;
    int errors     = 0;
    int wr_count   = 0;
    int done_count = 0;
    int err_count  = 0;
    int both_count = 0;

    uart_rx_img_loader #(
        .ADDR_W         (ADDR_W),
        .IMG_BYTES      (IMG_BYTES),
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    // Event tallies, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_we)                wr_count++;
        if (load_done)             done_count++;
        if (load_err)              err_count++;
        if (load_done && load_err) both_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one tick from a falling edge and checks the resulting write one clock later.
    task automatic send_byte(input logic [7:0] d, input logic [ADDR_W-1:0] a, input logic last);
        logic [CW-1:0] exp_cnt;
        exp_cnt = CW'(a) + CW'(1);
        rx_done_tick = 1'b1;
        rx_data      = d;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we[%0d]: got %b expected 1", a, mem_we); end
        checks++; if (mem_addr !== a) begin errors++; $display("FAIL wr_addr[%0d]: got %0d expected %0d", a, mem_addr, a); end
        checks++; if (mem_wdata !== d) begin errors++; $display("FAIL wr_data[%0d]: got %h expected %h", a, mem_wdata, d); end
        checks++; if (byte_count !== exp_cnt) begin errors++; $display("FAIL wr_count[%0d]: got %0d expected %0d", a, byte_count, exp_cnt); end
        checks++; if (load_done !== last) begin errors++; $display("FAIL wr_done[%0d]: got %b expected %b", a, load_done, last); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL wr_err[%0d]: got %b expected 0", a, load_err); end
        checks++; if (busy !== !last) begin errors++; $display("FAIL wr_busy[%0d]: got %b expected %b", a, busy, !last); end
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h expected 00", mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", load_err); end
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", byte_count); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_spaced_load();
        logic [7:0] d [4];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL spaced_armed_busy: got %b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            idle(9);
            send_byte(d[i], ADDR_W'(i), i == 3);
        end
        idle(1);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL spaced_we_after: got %b expected 0", mem_we); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL spaced_done_after: got %b expected 0", load_done); end
        checks++; if (byte_count !== CW'(4)) begin errors++; $display("FAIL spaced_count_hold: got %0d expected 4", byte_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spaced_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL b2b_count_clear: got %0d expected 0", byte_count); end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA0 + 8'(i), ADDR_W'(i), i == 3);
        end
        idle(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int e0;
        int w0;
        e0 = err_count;
        pulse_start();
        idle(30);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL armed_no_timeout_busy: got %b expected 1", busy); end
        checks++; if (err_count !== e0) begin errors++; $display("FAIL armed_no_timeout_err: got %0d expected %0d", err_count, e0); end
        send_byte(8'h5A, 4'd0, 1'b0);
        send_byte(8'hA5, 4'd1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (load_err !== (k == 20)) begin
                errors++; $display("FAIL to_err_cycle%0d: got %b expected %b", k, load_err, k == 20);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
        checks++; if (byte_count !== CW'(2)) begin errors++; $display("FAIL to_count: got %0d expected 2", byte_count); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL to_done: got %b expected 0", load_done); end
        @(negedge clk);
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse_width: got %b expected 0", load_err); end
        w0 = wr_count;
        rx_done_tick = 1'b1; rx_data = 8'h99;
        @(negedge clk);
        rx_done_tick = 1'b0;
        idle(2);
        checks++; if (wr_count !== w0) begin errors++; $display("FAIL to_late_tick_writes: got %0d expected %0d", wr_count, w0); end
    endtask

    task automatic test_ignored_inputs();
        rx_done_tick = 1'b1; rx_data = 8'hEE;
        @(negedge clk);
        rx_done_tick = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_tick_we: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_tick_busy: got %b expected 0", busy); end
        start = 1'b1; rx_done_tick = 1'b1; rx_data = 8'hDD;
        @(negedge clk);
        start = 1'b0; rx_done_tick = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL start_tick_we: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_tick_busy: got %b expected 1", busy); end
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL start_tick_count: got %0d expected 0", byte_count); end
        send_byte(8'h55, 4'd0, 1'b0);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_start_busy: got %b expected 1", busy); end
        checks++; if (byte_count !== CW'(1)) begin errors++; $display("FAIL load_start_count: got %0d expected 1", byte_count); end
        send_byte(8'h66, 4'd1, 1'b0);
        send_byte(8'h77, 4'd2, 1'b0);
        send_byte(8'h88, 4'd3, 1'b1);
        idle(1);
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h01, 4'd0, 1'b0);
        send_byte(8'h02, 4'd1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL mid_rst_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL mid_rst_wdata: got %h expected 00", mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", byte_count); end
        @(negedge clk);
        rx_done_tick = 1'b1; rx_data = 8'h33;
        @(negedge clk);
        rx_done_tick = 1'b0;
        reset = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_tick_we: got %b expected 0", mem_we); end
        idle(1);
        pulse_start();
        send_byte(8'h09, 4'd0, 1'b0);
        send_byte(8'h0A, 4'd1, 1'b0);
        send_byte(8'h0B, 4'd2, 1'b0);
        send_byte(8'h0C, 4'd3, 1'b1);
        idle(1);
    endtask

    task automatic test_tick_on_expiry();
        pulse_start();
        send_byte(8'hC1, 4'd0, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            checks++;
            if (load_err !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL expiry_wait%0d: got err=%b busy=%b expected err=0 busy=1", k, load_err, busy);
            end
        end
        send_byte(8'hC2, 4'd1, 1'b0);
        idle(19);
        send_byte(8'hC3, 4'd2, 1'b0);
        send_byte(8'hC4, 4'd3, 1'b1);
        idle(1);
    endtask

    task automatic test_totals();
        checks++; if (wr_count !== 24) begin errors++; $display("FAIL total_writes: got %0d expected 24", wr_count); end
        checks++; if (done_count !== 5) begin errors++; $display("FAIL total_done: got %0d expected 5", done_count); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL total_err: got %0d expected 1", err_count); end
        checks++; if (both_count !== 0) begin errors++; $display("FAIL done_and_err_together: got %0d expected 0", both_count); end
    endtask

    initial begin
        test_reset();
        test_spaced_load();
        test_back_to_back();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_load();
        test_tick_on_expiry();
        test_totals();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
